// File: rtl/bacc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bacc_pkg: card types, point/score helpers, deal FSM states            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bacc_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_BLANK = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_KING  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } deal_state_t;

  // Blank and 1..9 count at face value; 10..13 count as zero.
  function automatic logic [3:0] card_points(input card_t c);
    card_points = (c <= 4'd9) ? c : 4'd0;
  endfunction

  // Three-card sum never exceeds 27, so two conditional subtractions suffice.
  function automatic logic [3:0] score_mod10(input logic [4:0] s);
    logic [4:0] r;
    if (s >= 5'd20)      r = s - 5'd20;
    else if (s >= 5'd10) r = s - 5'd10;
    else                 r = s;
    score_mod10 = r[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | card_source: free-running card counter, 1..CARD_MAX, wraps to 1       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module card_source
  import bacc_pkg::*;
#(
  parameter int CARD_MAX = 13
) (
  input  logic       slow_clock,
  input  logic       resetb,
  output logic [3:0] new_card
);

  localparam card_t c_MAX = card_t'(CARD_MAX);

  card_t r_card;

  always_ff @(posedge slow_clock) begin
    if (!resetb)               r_card <= CARD_ACE;
    else if (r_card >= c_MAX)  r_card <= CARD_ACE;
    else                       r_card <= r_card + 4'd1;
  end

  assign new_card = r_card;

endmodule
`default_nettype wire

// File: rtl/card_dealer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | card_dealer: handshaked dealing into player/banker hands with scores  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module card_dealer
  import bacc_pkg::*;
#(
  parameter int CARD_MAX = 13,
  parameter int SLOTS    = 3
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic       deal_who,
  input  logic       clear,
  output logic       deal_ack,
  output logic       deal_err,
  output logic [3:0] new_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [1:0] pcount,
  output logic [1:0] dcount,
  output logic [3:0] pscore,
  output logic [3:0] dscore
);

  card_t       w_new_card;
  deal_state_t r_state;
  deal_state_t w_state_nxt;
  logic        w_write;
  logic        w_err_nxt;
  logic        r_ack;
  logic        r_err;
  logic [1:0]  w_full;
  logic        w_sel_full;

  card_source #(.CARD_MAX(CARD_MAX)) u_source (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .new_card   (w_new_card)
  );

  assign w_sel_full = deal_who ? w_full[1] : w_full[0];

  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (deal_req) begin
          w_state_nxt = ST_ACK;
          if (w_sel_full) w_err_nxt = 1'b1;
          else            w_write   = 1'b1;
        end
      end
      ST_ACK:  w_state_nxt = ST_HOLD;
      ST_HOLD: if (!deal_req) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    // Clear wins over a deal; a still-held request must be released first.
    if (clear) begin
      w_state_nxt = deal_req ? ST_HOLD : ST_IDLE;
      w_write     = 1'b0;
      w_err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_write;
      r_err   <= w_err_nxt;
    end
  end

  for (genvar h = 0; h < 2; h++) begin : g_hand
    localparam logic c_WHO = (h == 1);

    card_t      r_card [SLOTS];
    logic [1:0] r_count;
    logic [3:0] r_score;
    card_t      w_next [SLOTS];
    logic [4:0] w_sum;
    logic       w_sel;

    assign w_sel     = w_write && (deal_who == c_WHO);
    assign w_full[h] = (r_count == 2'(SLOTS));

    // Score comes from the post-write card set so it is valid in the ack cycle.
    always_comb begin
      w_sum = 5'd0;
      for (int s = 0; s < SLOTS; s++) begin
        w_next[s] = r_card[s];
        if (w_sel && (r_count == 2'(s))) w_next[s] = w_new_card;
        w_sum = w_sum + {1'b0, card_points(w_next[s])};
      end
    end

    always_ff @(posedge slow_clock) begin
      if (!resetb || clear) begin
        for (int s = 0; s < SLOTS; s++) r_card[s] <= CARD_BLANK;
        r_count <= 2'd0;
        r_score <= 4'd0;
      end else if (w_sel) begin
        for (int s = 0; s < SLOTS; s++) r_card[s] <= w_next[s];
        r_count <= r_count + 2'd1;
        r_score <= score_mod10(w_sum);
      end
    end
  end

  assign deal_ack = r_ack;
  assign deal_err = r_err;
  assign new_card = w_new_card;
  assign pcard1   = g_hand[0].r_card[0];
  assign pcard2   = g_hand[0].r_card[1];
  assign pcard3   = g_hand[0].r_card[2];
  assign dcard1   = g_hand[1].r_card[0];
  assign dcard2   = g_hand[1].r_card[1];
  assign dcard3   = g_hand[1].r_card[2];
  assign pcount   = g_hand[0].r_count;
  assign dcount   = g_hand[1].r_count;
  assign pscore   = g_hand[0].r_score;
  assign dscore   = g_hand[1].r_score;

endmodule
`default_nettype wire

// File: tb/tb_card_dealer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_card_dealer: directed table-driven bench for card_dealer           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       resetb;
  logic       deal_req;
  logic       deal_who;
  logic       clear;
  logic       deal_ack;
  logic       deal_err;
  logic [3:0] new_card;
  logic [3:0] pcard1, pcard2, pcard3;
  logic [3:0] dcard1, dcard2, dcard3;
  logic [1:0] pcount, dcount;
  logic [3:0] pscore, dscore;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] m_nc;

  card_dealer dut (
    .slow_clock (clk),
    .resetb     (resetb),
    .deal_req   (deal_req),
    .deal_who   (deal_who),
    .clear      (clear),
    .deal_ack   (deal_ack),
    .deal_err   (deal_err),
    .new_card   (new_card),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pcount     (pcount),
    .dcount     (dcount),
    .pscore     (pscore),
    .dscore     (dscore)
  );

  always #5 clk = ~clk;

  // Reference card source: 1..13 wrapping, forced to 1 by reset.
  always @(posedge clk) begin
    if (!resetb)           m_nc <= 4'd1;
    else if (m_nc == 4'd13) m_nc <= 4'd1;
    else                    m_nc <= m_nc + 4'd1;
  end

  typedef struct {
    logic       who;
    logic [3:0] card;
    logic       ack;
    logic       err;
    logic [1:0] pc;
    logic [1:0] dc;
    logic [3:0] ps;
    logic [3:0] ds;
    logic [3:0] p1, p2, p3;
    logic [3:0] d1, d2, d3;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_card(input logic [3:0] v);
    int n = 0;
    while (new_card !== v && n < 20) begin
      tick();
      n++;
    end
    check("wait_card_found", {7'd0, new_card === v}, 8'd1);
  endtask

  task automatic check_zero_hands(input string tag);
    check({tag, "_pcard1"}, {4'd0, pcard1}, 8'd0);
    check({tag, "_pcard2"}, {4'd0, pcard2}, 8'd0);
    check({tag, "_pcard3"}, {4'd0, pcard3}, 8'd0);
    check({tag, "_dcard1"}, {4'd0, dcard1}, 8'd0);
    check({tag, "_dcard2"}, {4'd0, dcard2}, 8'd0);
    check({tag, "_dcard3"}, {4'd0, dcard3}, 8'd0);
    check({tag, "_pcount"}, {6'd0, pcount}, 8'd0);
    check({tag, "_dcount"}, {6'd0, dcount}, 8'd0);
    check({tag, "_pscore"}, {4'd0, pscore}, 8'd0);
    check({tag, "_dscore"}, {4'd0, dscore}, 8'd0);
  endtask

  initial begin
    int acks;

    //          who card ack err pc dc ps ds  p1 p2 p3  d1  d2  d3
    vecs[0] = '{1'b0, 4'd9,  1'b1, 1'b0, 2'd1, 2'd0, 4'd9, 4'd0, 4'd9, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0};
    vecs[1] = '{1'b0, 4'd8,  1'b1, 1'b0, 2'd2, 2'd0, 4'd7, 4'd0, 4'd9, 4'd8, 4'd0, 4'd0,  4'd0, 4'd0};
    vecs[2] = '{1'b1, 4'd13, 1'b1, 1'b0, 2'd2, 2'd1, 4'd7, 4'd0, 4'd9, 4'd8, 4'd0, 4'd13, 4'd0, 4'd0};
    vecs[3] = '{1'b1, 4'd1,  1'b1, 1'b0, 2'd2, 2'd2, 4'd7, 4'd1, 4'd9, 4'd8, 4'd0, 4'd13, 4'd1, 4'd0};
    vecs[4] = '{1'b0, 4'd5,  1'b1, 1'b0, 2'd3, 2'd2, 4'd2, 4'd1, 4'd9, 4'd8, 4'd5, 4'd13, 4'd1, 4'd0};
    vecs[5] = '{1'b0, 4'd3,  1'b0, 1'b1, 2'd3, 2'd2, 4'd2, 4'd1, 4'd9, 4'd8, 4'd5, 4'd13, 4'd1, 4'd0};
    vecs[6] = '{1'b1, 4'd12, 1'b1, 1'b0, 2'd3, 2'd3, 4'd2, 4'd1, 4'd9, 4'd8, 4'd5, 4'd13, 4'd1, 4'd12};
    vecs[7] = '{1'b1, 4'd7,  1'b0, 1'b1, 2'd3, 2'd3, 4'd2, 4'd1, 4'd9, 4'd8, 4'd5, 4'd13, 4'd1, 4'd12};

    resetb = 1'b0; deal_req = 1'b0; deal_who = 1'b0; clear = 1'b0;
    tick(); tick();
    check_zero_hands("rst");
    check("rst_ack", {7'd0, deal_ack}, 8'd0);
    check("rst_err", {7'd0, deal_err}, 8'd0);
    check("rst_new_card", {4'd0, new_card}, 8'd1);

    // Free-running source: cycle k after release shows (k mod 13) + 1.
    resetb = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check("src_seq", {4'd0, new_card}, 8'((k % 13) + 1));
      check("src_range", {7'd0, (new_card >= 4'd1) && (new_card <= 4'd13)}, 8'd1);
    end

    // Table: deals into both hands including full-hand errors.
    for (int i = 0; i < 8; i++) begin
      wait_card(vecs[i].card);
      deal_who = vecs[i].who;
      deal_req = 1'b1;
      tick();
      check("tbl_ack",    {7'd0, deal_ack}, {7'd0, vecs[i].ack});
      check("tbl_err",    {7'd0, deal_err}, {7'd0, vecs[i].err});
      check("tbl_pcount", {6'd0, pcount},   {6'd0, vecs[i].pc});
      check("tbl_dcount", {6'd0, dcount},   {6'd0, vecs[i].dc});
      check("tbl_pscore", {4'd0, pscore},   {4'd0, vecs[i].ps});
      check("tbl_dscore", {4'd0, dscore},   {4'd0, vecs[i].ds});
      check("tbl_pcard1", {4'd0, pcard1},   {4'd0, vecs[i].p1});
      check("tbl_pcard2", {4'd0, pcard2},   {4'd0, vecs[i].p2});
      check("tbl_pcard3", {4'd0, pcard3},   {4'd0, vecs[i].p3});
      check("tbl_dcard1", {4'd0, dcard1},   {4'd0, vecs[i].d1});
      check("tbl_dcard2", {4'd0, dcard2},   {4'd0, vecs[i].d2});
      check("tbl_dcard3", {4'd0, dcard3},   {4'd0, vecs[i].d3});
      deal_req = 1'b0;
      tick();
      check("tbl_ack_pulse", {7'd0, deal_ack}, 8'd0);
      check("tbl_err_pulse", {7'd0, deal_err}, 8'd0);
      tick();
    end

    // Reset asserted during a handshake, request still held.
    deal_who = 1'b1; deal_req = 1'b1;
    tick();
    check("mid_err", {7'd0, deal_err}, 8'd1);
    resetb = 1'b0;
    tick();
    tick();
    check_zero_hands("mid_rst");
    check("mid_rst_ack", {7'd0, deal_ack}, 8'd0);
    check("mid_rst_err", {7'd0, deal_err}, 8'd0);
    check("mid_rst_nc", {4'd0, new_card}, 8'd1);
    resetb = 1'b1; deal_req = 1'b0;
    tick();
    check("mid_nc2", {4'd0, new_card}, 8'd2);
    tick();
    check("mid_nc3", {4'd0, new_card}, 8'd3);
    deal_who = 1'b0; deal_req = 1'b1;
    tick();
    check("mid_idle_ack", {7'd0, deal_ack}, 8'd1);
    check("mid_idle_pcard1", {4'd0, pcard1}, 8'd3);
    deal_req = 1'b0;
    tick(); tick();

    // Held request deals exactly one card.
    acks = 0;
    deal_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (deal_ack === 1'b1) acks++;
    end
    check("hold_ack_count", 8'(acks), 8'd1);
    check("hold_pcount", {6'd0, pcount}, 8'd2);
    deal_req = 1'b0;
    tick(); tick();
    deal_req = 1'b1;
    tick();
    check("hold_second_ack", {7'd0, deal_ack}, 8'd1);
    check("hold_second_pcount", {6'd0, pcount}, 8'd3);
    deal_req = 1'b0;
    tick(); tick();

    // Clear and request on the same edge: clear wins, FSM waits for release.
    clear = 1'b1; deal_req = 1'b1; deal_who = 1'b0;
    tick();
    check_zero_hands("clr");
    check("clr_ack", {7'd0, deal_ack}, 8'd0);
    check("clr_nc", {4'd0, new_card}, {4'd0, m_nc});
    clear = 1'b0;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (deal_ack === 1'b1 || deal_err === 1'b1) acks++;
      check("clr_hold_nc", {4'd0, new_card}, {4'd0, m_nc});
    end
    check("clr_hold_no_ack", 8'(acks), 8'd0);
    check("clr_hold_pcount", {6'd0, pcount}, 8'd0);
    deal_req = 1'b0;
    tick();
    deal_who = 1'b1; deal_req = 1'b1;
    tick();
    check("clr_after_ack", {7'd0, deal_ack}, 8'd1);
    check("clr_after_dcount", {6'd0, dcount}, 8'd1);
    deal_req = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
